// File: rtl/miniscope_rd_ctrl.sv
// miniscope_rd_ctrl
//   Sequencer for the miniscope dual-port FIFO RAM (2^RAM_ADRB words of
//   2*RAM_WIDTH data bits plus one parity bit per byte lane).
//   The write side keeps a free-running circular write pointer. The read side
//   turns a readout request into a look-back burst of read addresses. It then
//   re-times the RAM output into a valid-qualified word stream and collects
//   the parity errors seen during the burst.
//
// Ports
//   clock            TMB 40 MHz main clock
//   reset            synchronous, active-high reset
//   mini_run         write miniscope data every bx
//   mini_rd_start    1-cycle readout request
//   mini_tbins       number of words to read for this request
//   mini_offset      look-back distance from the current write address
//   fifo_wen         RAM write enable
//   fifo_wadr_mini   RAM write address
//   fifo_radr_mini   RAM read address
//   fifo_rdata_mini  RAM read data (RAM registers its output once)
//   parity_err_mini  per-lane parity error, aligned with fifo_rdata_mini
//   mini_rd_data     readout word
//   mini_rd_valid    mini_rd_data is valid this cycle
//   mini_busy        readout in progress
//   mini_done        1-cycle pulse after the last word
//   mini_perr        sticky per-lane parity error of the current/last readout
//   mini_overlap_err sticky: request arrived while a readout was in progress
module miniscope_rd_ctrl #(
  parameter int RAM_ADRB  = 11,
  parameter int RAM_WIDTH = 8,
  parameter int TBIN_BITS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mini_run,
  input  logic                   mini_rd_start,
  input  logic [TBIN_BITS-1:0]   mini_tbins,
  input  logic [RAM_ADRB-1:0]    mini_offset,
  output logic                   fifo_wen,
  output logic [RAM_ADRB-1:0]    fifo_wadr_mini,
  output logic [RAM_ADRB-1:0]    fifo_radr_mini,
  input  logic [2*RAM_WIDTH-1:0] fifo_rdata_mini,
  input  logic [1:0]             parity_err_mini,
  output logic [2*RAM_WIDTH-1:0] mini_rd_data,
  output logic                   mini_rd_valid,
  output logic                   mini_busy,
  output logic                   mini_done,
  output logic [1:0]             mini_perr,
  output logic                   mini_overlap_err
);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  localparam logic [TBIN_BITS-1:0] TB_ONE  = TBIN_BITS'(1);
  localparam logic [RAM_ADRB-1:0]  ADR_ONE = RAM_ADRB'(1);

  state_t               state, state_nxt;
  logic [TBIN_BITS-1:0] tbins_q;
  logic [TBIN_BITS-1:0] rd_cnt;
  logic                 flush_cnt;
  logic                 accept;
  logic                 last_adr;
  logic                 vld_p1;

  // Look-back start address; modulo arithmetic gives the wrap below zero.
  function automatic logic [RAM_ADRB-1:0] lookback(
    input logic [RAM_ADRB-1:0] wadr,
    input logic [RAM_ADRB-1:0] offset
  );
    return wadr - offset;
  endfunction

  assign accept   = (state == IDLE) && mini_rd_start && (mini_tbins != '0);
  assign last_adr = (rd_cnt == (tbins_q - TB_ONE));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mini_busy = 1'b0;
    mini_done = 1'b0;
    case (state)
      IDLE: begin
        if (mini_rd_start) state_nxt = (mini_tbins == '0) ? DONE : READ;
      end
      READ: begin
        mini_busy = 1'b1;
        if (last_adr) state_nxt = FLUSH;
      end
      FLUSH: begin
        mini_busy = 1'b1;
        if (flush_cnt) state_nxt = DONE;
      end
      DONE: begin
        mini_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write side: independent of the readout FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_wen       <= 1'b0;
      fifo_wadr_mini <= '0;
    end else begin
      fifo_wen <= mini_run;
      if (fifo_wen) fifo_wadr_mini <= fifo_wadr_mini + ADR_ONE;
    end
  end

  // Stage p0: read address issue; the read address holds when not reading.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_radr_mini   <= '0;
      tbins_q          <= '0;
      rd_cnt           <= '0;
      flush_cnt        <= 1'b0;
      mini_overlap_err <= 1'b0;
    end else begin
      if (accept) begin
        tbins_q        <= mini_tbins;
        rd_cnt         <= '0;
        fifo_radr_mini <= lookback(fifo_wadr_mini, mini_offset);
      end else if ((state == READ) && !last_adr) begin
        rd_cnt         <= rd_cnt + TB_ONE;
        fifo_radr_mini <= fifo_radr_mini + ADR_ONE;
      end
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      if (mini_rd_start && (state != IDLE)) mini_overlap_err <= 1'b1;
    end
  end

  // Stage p1: RAM output register holds the word addressed one cycle ago.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      mini_rd_valid <= 1'b0;
      mini_perr     <= 2'b00;
    end else begin
      vld_p1        <= (state == READ);
      mini_rd_valid <= vld_p1;
      if (accept)      mini_perr <= 2'b00;
      else if (vld_p1) mini_perr <= mini_perr | parity_err_mini;
    end
  end

  // Stage p2: output word register, loaded only when a word arrives.
  always_ff @(posedge clock) begin
    if (reset)       mini_rd_data <= '0;
    else if (vld_p1) mini_rd_data <= fifo_rdata_mini;
  end

endmodule

// File: tb/tb_miniscope_rd_ctrl.sv
module tb_miniscope_rd_ctrl;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          mini_run;
  logic          mini_rd_start;
  logic [TW-1:0] mini_tbins;
  logic [AW-1:0] mini_offset;
  logic          fifo_wen;
  logic [AW-1:0] fifo_wadr_mini;
  logic [AW-1:0] fifo_radr_mini;
  logic [DW-1:0] fifo_rdata_mini;
  logic [1:0]    parity_err_mini;
  logic [DW-1:0] mini_rd_data;
  logic          mini_rd_valid;
  logic          mini_busy;
  logic          mini_done;
  logic [1:0]    mini_perr;
  logic          mini_overlap_err;

  always #5 clock = ~clock;

  miniscope_rd_ctrl #(.RAM_ADRB(AW), .RAM_WIDTH(8), .TBIN_BITS(TW)) dut (
    .clock(clock), .reset(reset), .mini_run(mini_run),
    .mini_rd_start(mini_rd_start), .mini_tbins(mini_tbins),
    .mini_offset(mini_offset), .fifo_wen(fifo_wen),
    .fifo_wadr_mini(fifo_wadr_mini), .fifo_radr_mini(fifo_radr_mini),
    .fifo_rdata_mini(fifo_rdata_mini), .parity_err_mini(parity_err_mini),
    .mini_rd_data(mini_rd_data), .mini_rd_valid(mini_rd_valid),
    .mini_busy(mini_busy), .mini_done(mini_done), .mini_perr(mini_perr),
    .mini_overlap_err(mini_overlap_err)
  );

  // RAM stand-in: registered read of an address-derived word.
  logic          par_mode = 1'b0;
  logic [AW-1:0] par_addr = '0;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = ({21'd0, a} * 32'h9E37) ^ 32'h5A5A;
    return t[15:0];
  endfunction

  always @(posedge clock) begin
    fifo_rdata_mini <= ram_word(fifo_radr_mini);
    if (par_mode) parity_err_mini <= (fifo_radr_mini == par_addr) ? 2'b10 : 2'b00;
    else          parity_err_mini <= (($urandom % 6) == 0) ? 2'($urandom) : 2'b00;
  end

  // Behavioural model: expectations scheduled per absolute cycle number.
  int            cyc = 0;
  bit            model_ok = 1'b0;
  bit            exp_vld  [int];
  logic [DW-1:0] exp_data [int];
  logic [AW-1:0] exp_radr [int];
  bit            exp_done [int];
  bit            exp_busy [int];
  logic [AW-1:0] m_wadr, m_radr, m_start;
  logic          m_wen, m_ovl;
  logic [1:0]    m_perr;
  int            m_free, m_c, m_n;

  initial forever begin
    @(posedge clock);
    m_c = cyc;
    if (reset) begin
      exp_vld.delete(); exp_data.delete(); exp_radr.delete();
      exp_done.delete(); exp_busy.delete();
      m_wadr = '0; m_radr = '0; m_wen = 1'b0; m_ovl = 1'b0; m_perr = 2'b00;
      m_free = m_c + 1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (mini_rd_start && (m_c >= m_free) && (mini_tbins != 0)) m_perr = 2'b00;
      else if (exp_vld.exists(m_c + 1)) m_perr = m_perr | parity_err_mini;
      if (mini_rd_start) begin
        if (m_c < m_free) m_ovl = 1'b1;
        else if (mini_tbins == 0) begin
          exp_done[m_c + 1] = 1'b1;
          m_free = m_c + 2;
        end else begin
          m_start = m_wadr - mini_offset;
          m_n = int'(mini_tbins);
          for (int k = 0; k < m_n; k++) begin
            exp_radr[m_c + 1 + k] = m_start + AW'(k);
            exp_vld[m_c + 3 + k]  = 1'b1;
            exp_data[m_c + 3 + k] = ram_word(m_start + AW'(k));
          end
          for (int b = m_c + 1; b <= m_c + m_n + 2; b++) exp_busy[b] = 1'b1;
          exp_done[m_c + m_n + 3] = 1'b1;
          m_free = m_c + m_n + 4;
        end
      end
      m_wadr = m_wadr + AW'(m_wen);
      m_wen  = mini_run;
      if (exp_radr.exists(m_c + 1)) m_radr = exp_radr[m_c + 1];
    end
    cyc = m_c + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (model_ok) begin
      chk("wen", 32'(fifo_wen), 32'(m_wen));
      chk("wadr", 32'(fifo_wadr_mini), 32'(m_wadr));
      chk("radr", 32'(fifo_radr_mini), 32'(m_radr));
      chk("valid", 32'(mini_rd_valid), 32'(exp_vld.exists(cyc)));
      if (exp_vld.exists(cyc)) chk("data", 32'(mini_rd_data), 32'(exp_data[cyc]));
      chk("done", 32'(mini_done), 32'(exp_done.exists(cyc)));
      chk("busy", 32'(mini_busy), 32'(exp_busy.exists(cyc)));
      chk("perr", 32'(mini_perr), 32'(m_perr));
      chk("overlap", 32'(mini_overlap_err), 32'(m_ovl));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic request(input int tb, input int off);
    mini_rd_start = 1'b1;
    mini_tbins    = TW'(tb);
    mini_offset   = AW'(off);
    step(1);
    mini_rd_start = 1'b0;
  endtask

  int e_radr  [8] = '{80, 81, 82, 83, 83, 83, 83, 83};
  int e_valid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int e_done  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int e_busy  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
  int w_radr  [4] = '{2046, 2047, 0, 1};
  int nvalid;
  int tbr;

  initial begin
    reset = 1'b1; mini_run = 1'b0; mini_rd_start = 1'b0;
    mini_tbins = '0; mini_offset = '0;
    step(3);
    reset = 1'b0;

    // Write sweep with wrap.
    do_reset();
    mini_run = 1'b1;
    step(1);
    @(negedge clock); chk("sweep_wen", 32'(fifo_wen), 1); chk("sweep_w0", 32'(fifo_wadr_mini), 0);
    step(2047);
    @(negedge clock); chk("sweep_w2047", 32'(fifo_wadr_mini), 2047);
    step(1);
    @(negedge clock); chk("sweep_wrap0", 32'(fifo_wadr_mini), 0);
    step(1);
    @(negedge clock); chk("sweep_wrap1", 32'(fifo_wadr_mini), 1); chk("sweep_wen2", 32'(fifo_wen), 1);

    // Basic readout: wadr=100, offset=20, tbins=4.
    step(1);
    do_reset();
    mini_run = 1'b1;
    step(101);
    @(negedge clock); chk("basic_wadr", 32'(fifo_wadr_mini), 100);
    request(4, 20);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("basic_radr", 32'(fifo_radr_mini), 32'(e_radr[i]));
      chk("basic_valid", 32'(mini_rd_valid), 32'(e_valid[i]));
      chk("basic_done", 32'(mini_done), 32'(e_done[i]));
      chk("basic_busy", 32'(mini_busy), 32'(e_busy[i]));
      step(1);
    end

    // Wrap look-back: wadr=3, offset=5.
    do_reset();
    mini_run = 1'b1;
    step(4);
    @(negedge clock); chk("wrap_wadr", 32'(fifo_wadr_mini), 3);
    request(4, 5);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i < 4) chk("wrap_radr", 32'(fifo_radr_mini), 32'(w_radr[i]));
      nvalid += int'(mini_rd_valid);
      step(1);
    end
    chk("wrap_nvalid", 32'(nvalid), 4);

    // Zero tbins: done next cycle, never busy, no words.
    request(0, 7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("zero_done", 32'(mini_done), (i == 0) ? 32'd1 : 32'd0);
      chk("zero_busy", 32'(mini_busy), 0);
      chk("zero_valid", 32'(mini_rd_valid), 0);
      step(1);
    end

    // Overlap and parity on word 2.
    par_mode = 1'b1;
    par_addr = m_wadr - AW'(10) + AW'(2);
    request(4, 10);
    @(negedge clock); chk("par_clr", 32'(mini_perr), 0);
    step(1);
    request(9, 3);
    @(negedge clock); chk("ovl_set", 32'(mini_overlap_err), 1); chk("par_w0", 32'(mini_perr), 0);
    step(1);
    @(negedge clock); chk("par_w1", 32'(mini_perr), 0);
    step(1);
    @(negedge clock); chk("par_w2", 32'(mini_perr), 2);
    step(3);
    @(negedge clock); chk("par_hold", 32'(mini_perr), 2); chk("ovl_busy", 32'(mini_busy), 0);
    request(2, 10);
    @(negedge clock); chk("par_next_clr", 32'(mini_perr), 0); chk("ovl_sticky", 32'(mini_overlap_err), 1);
    step(6);
    par_mode = 1'b0;

    // Reset mid-burst.
    request(16, 40);
    step(4);
    do_reset();
    @(negedge clock);
    chk("rst_wen", 32'(fifo_wen), 0);
    chk("rst_wadr", 32'(fifo_wadr_mini), 0);
    chk("rst_radr", 32'(fifo_radr_mini), 0);
    chk("rst_valid", 32'(mini_rd_valid), 0);
    chk("rst_data", 32'(mini_rd_data), 0);
    chk("rst_busy", 32'(mini_busy), 0);
    chk("rst_done", 32'(mini_done), 0);
    chk("rst_perr", 32'(mini_perr), 0);
    chk("rst_ovl", 32'(mini_overlap_err), 0);
    for (int i = 0; i < 25; i++) begin
      step(1);
      @(negedge clock);
      chk("rst_no_done", 32'(mini_done), 0);
      chk("rst_no_valid", 32'(mini_rd_valid), 0);
    end
    request(3, 8);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      nvalid += int'(mini_rd_valid);
      step(1);
    end
    chk("rst_recover_nvalid", 32'(nvalid), 3);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      mini_run = (($urandom % 8) != 0);
      reset    = (($urandom % 1500) == 0);
      if (($urandom % 12) == 0) begin
        tbr = int'($urandom % 32);
        mini_rd_start = 1'b1;
        mini_tbins    = TW'(tbr);
        mini_offset   = AW'(tbr + 3 + int'($urandom % (2048 - tbr - 3)));
      end else begin
        mini_rd_start = 1'b0;
      end
      step(1);
    end
    reset = 1'b0;
    mini_rd_start = 1'b0;
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miniscope_rd_ctrl.md
Name: miniscope_rd_ctrl

Overview:
- Sequencer for the miniscope 2048x16 (+2 parity) dual-port FIFO RAM.
- Write side: free-running circular write pointer and write enable.
- Read side: on a readout request, computes a look-back start address, issues a burst of read addresses, aligns the RAM output into a valid-qualified word stream for the DMB readout machine, and accumulates parity errors.
- Sits between the sequencer (L1A/readout requests) and the miniscope RAM block.

Parameters:
- RAM_ADRB, 11, RAM address width; depth = 2^RAM_ADRB.
- RAM_WIDTH, 8, bits per RAM byte lane; data word = 2*RAM_WIDTH.
- TBIN_BITS, 5, width of the tbins-per-readout count.

Ports:
- clock  in  1  TMB 40MHz main clock.
- reset  in  1  Synchronous, active-high reset.
- mini_run  in  1  1 = write miniscope data every bx.
- mini_rd_start  in  1  1-cycle readout request (L1A-aligned).
- mini_tbins  in  TBIN_BITS  Words to read per request.
- mini_offset  in  RAM_ADRB  Look-back distance from the current write address.
- fifo_wen  out  1  RAM write enable.
- fifo_wadr_mini  out  RAM_ADRB  RAM write address.
- fifo_radr_mini  out  RAM_ADRB  RAM read address.
- fifo_rdata_mini  in  2*RAM_WIDTH  RAM read data (1-clock registered RAM).
- parity_err_mini  in  2  RAM parity error, per byte lane, aligned with fifo_rdata_mini.
- mini_rd_data  out  2*RAM_WIDTH  Readout word.
- mini_rd_valid  out  1  mini_rd_data is valid this cycle.
- mini_busy  out  1  Readout in progress.
- mini_done  out  1  1-cycle pulse after the last word.
- mini_perr  out  2  Sticky per-lane parity error for the current/last readout.
- mini_overlap_err  out  1  Sticky: request arrived while busy.

Behaviour:
- Reset:
  - All outputs 0; write pointer 0; FSM in IDLE.
  - Reset mid-readout aborts at once: no mini_done, no further mini_rd_valid.
- Write side:
  - fifo_wen = registered mini_run.
  - wadr increments by 1 on every cycle fifo_wen=1, wrapping 2^RAM_ADRB-1 -> 0.
  - Write side runs independently of the readout FSM.
- Start address:
  - start = (wadr at the cycle mini_rd_start is sampled) - mini_offset, modulo 2^RAM_ADRB.
  - mini_offset=0 reads from the current write address.
  - Wrap below 0 is required, e.g. wadr=3, offset=5 -> 2046.
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE:
    - mini_rd_start=1 and mini_tbins!=0: latch start and tbins, clear mini_perr, go to READ, mini_busy=1 next cycle.
    - mini_rd_start=1 and mini_tbins=0: go directly to DONE; no words are output.
  - READ: drive fifo_radr_mini = start+k for k = 0..tbins-1, one per cycle, wrapping modulo depth. After the last address, go to FLUSH.
  - FLUSH: wait 2 cycles for RAM and output-register latency, then go to DONE.
  - DONE: mini_done=1 for one cycle, mini_busy=0, go to IDLE.
- Latency:
  - Address issued in cycle c yields mini_rd_valid=1 with that word in cycle c+2 (RAM register plus output register).
  - Words are contiguous, exactly tbins of them.
  - First radr is driven the cycle after the request is sampled.
  - mini_done asserts the cycle after the last valid word.
- fifo_radr_mini holds its last value when not reading.
- Parity:
  - On each mini_rd_valid cycle, mini_perr |= parity_err_mini (aligned with that word).
  - Sticky until the next accepted request or reset.
- Overlap:
  - mini_rd_start while FSM is not IDLE is ignored (no restart, no queueing).
  - Sets mini_overlap_err; cleared only by reset.
- Simultaneous events:
  - Request in the DONE cycle counts as overlap.
  - mini_run may change during a readout without affecting it.
  - No collision protection: the requester guarantees mini_offset >= tbins+3.

Test Plan:
- Write sweep: reset, mini_run=1 for 2050 cycles -> fifo_wadr_mini counts 0..2047, wraps to 0, 1; fifo_wen=1 throughout.
- Basic readout: wadr=100, offset=20, tbins=4, request -> radr 80,81,82,83 in consecutive cycles; 4 valid words 2 cycles later; mini_done the next cycle; busy low after.
- Wrap look-back: wadr=3, offset=5, tbins=4 -> radr 2046,2047,0,1; 4 valid words.
- Zero tbins: tbins=0 request -> no valid, mini_done pulse 1 cycle later, busy never asserted.
- Overlap and parity: second request mid-burst -> ignored, overlap_err=1; parity_err_mini=2'b10 on word 2 -> mini_perr=2'b10 until the next request clears it.
- Reset mid-burst: reset during READ of tbins=16 -> valid stops, no mini_done, all outputs 0, a new request works normally.
